// File: rtl/bram_stream_fifo_ctrl.sv
// Streaming FIFO controller for an attached true-dual-port BRAM: port A writes, port B reads,
// and a 2-entry output buffer turns the registered BRAM read into a valid/ready stream.
module bram_stream_fifo_ctrl #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [WIDTH-1:0]             s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [WIDTH-1:0]             m_data,
  output logic [$clog2(DEPTH+3)-1:0]   level,
  output logic                         ena,
  output logic                         wea,
  output logic [AW-1:0]                addra,
  output logic [WIDTH-1:0]             dia,
  output logic                         enb,
  output logic                         web,
  output logic [AW-1:0]                addrb,
  input  logic [WIDTH-1:0]             dob
);

  localparam int unsigned PW = AW - 1;
  localparam int unsigned LW = $clog2(DEPTH + 3);

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW-1:0]    mem_cnt_q, mem_cnt_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       out_cnt_q, out_cnt_d;
  logic [WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;

  logic       wr, pop, push;
  logic [2:0] occ;

  assign s_ready = rst_n & ~flush & (mem_cnt_q != AW'(DEPTH));
  assign wr      = s_valid & s_ready;
  assign m_valid = (out_cnt_q != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = buf0_q;
  // Buffer slots already claimed, counting the read still in flight.
  assign occ     = {1'b0, out_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign enb     = ~flush & (mem_cnt_q != '0) & (occ < 3'd2);
  assign push    = inflight_q & ~flush;

  assign ena   = wr;
  assign wea   = wr;
  assign addra = {1'b0, wptr_q};
  assign dia   = s_data;
  assign web   = 1'b0;
  assign addrb = {1'b0, rptr_q};
  assign level = LW'(mem_cnt_q) + LW'(inflight_q) + LW'(out_cnt_q);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mem_cnt_d  = mem_cnt_q;
    inflight_d = enb;
    out_cnt_d  = out_cnt_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      mem_cnt_d  = '0;
      inflight_d = 1'b0;
      out_cnt_d  = 2'd0;
    end else begin
      if (wr)  wptr_d = wptr_q + PW'(1);
      if (enb) rptr_d = rptr_q + PW'(1);
      mem_cnt_d = mem_cnt_q + AW'(wr) - AW'(enb);
      if (pop) begin
        buf0_d    = buf1_q;
        out_cnt_d = out_cnt_d - 2'd1;
      end
      // The returning word lands behind whatever survives this cycle's pop.
      if (push) begin
        if (out_cnt_d == 2'd0) buf0_d = dob;
        else                   buf1_d = dob;
        out_cnt_d = out_cnt_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
      out_cnt_q  <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
      out_cnt_q  <= out_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule
